// File: rtl/uart_tx_port.sv
// Store-mapped 8N1 UART transmitter: one byte is queued per store to ADDR, and a
// baud-rate FSM serializes the queue LSB first with back-to-back framing.
module uart_tx_port #(
    parameter int          CLK_HZ = 50000000,
    parameter int          BAUD   = 115200,
    parameter int          DEPTH  = 4,
    parameter logic [7:0]  ADDR   = 8'hFE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  Address,
    input  logic [7:0]  RegData,
    input  logic        EN,
    output logic        TxD,
    output logic        Busy,
    output logic        Full,
    output logic        Overflow,
    output logic [4:0]  Count
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int BCW = $clog2(DIV);
    localparam int PW  = $clog2(DEPTH);
    localparam logic [BCW-1:0] BC_LAST = BCW'(DIV - 1);
    localparam logic [4:0]     CNT_FULL = 5'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [BCW-1:0] bc_q, bc_d;
    logic [2:0]     bi_q, bi_d;
    logic [7:0]     shift_q, shift_d;
    logic           txd_q, txd_d;
    logic           busy_q;
    logic           full_q;
    logic           overflow_q;
    logic [4:0]     count_q, count_d;
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic           wq_q;
    logic [7:0]     mem_q [DEPTH];

    logic wq_s, push_s, push_ok_s, pop_s;

    // EN is held for many clk cycles per store, so only its rising edge pushes.
    assign wq_s      = EN & (Address == ADDR);
    assign push_s    = wq_s & ~wq_q;
    assign push_ok_s = push_s & ~full_q;

    // FIFO occupancy; full is judged on the pre-pop count.
    always_comb begin
        count_d = count_q;
        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase
    end

    // Frame sequencer: next state, baud/bit counters, shifter and line level.
    always_comb begin
        state_d = state_q;
        bc_d    = bc_q;
        bi_d    = bi_q;
        shift_d = shift_q;
        pop_s   = 1'b0;
        case (state_q)
            IDLE: begin
                bc_d = {BCW{1'b0}};
                if (count_q != 5'd0) begin
                    pop_s   = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (bc_q == BC_LAST) begin
                    bc_d    = {BCW{1'b0}};
                    bi_d    = 3'd0;
                    state_d = DATA;
                end else begin
                    bc_d = bc_q + BCW'(1);
                end
            end
            DATA: begin
                if (bc_q == BC_LAST) begin
                    bc_d    = {BCW{1'b0}};
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bi_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bi_d = bi_q + 3'd1;
                    end
                end else begin
                    bc_d = bc_q + BCW'(1);
                end
            end
            STOP: begin
                if (bc_q == BC_LAST) begin
                    bc_d = {BCW{1'b0}};
                    if (count_q != 5'd0) begin
                        pop_s   = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    bc_d = bc_q + BCW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                bc_d    = {BCW{1'b0}};
                bi_d    = 3'd0;
            end
        endcase

        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    // State, counters, pointers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bc_q       <= {BCW{1'b0}};
            bi_q       <= 3'd0;
            shift_q    <= 8'h00;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            count_q    <= 5'd0;
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            wq_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            bc_q       <= bc_d;
            bi_q       <= bi_d;
            shift_q    <= shift_d;
            txd_q      <= txd_d;
            busy_q     <= (state_d != IDLE);
            full_q     <= (count_d == CNT_FULL);
            overflow_q <= overflow_q | (push_s & full_q);
            count_q    <= count_d;
            wq_q       <= wq_s;
            if (push_ok_s) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    // FIFO storage needs no reset; the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= RegData;
        end
    end

    assign TxD      = txd_q;
    assign Busy     = busy_q;
    assign Full     = full_q;
    assign Overflow = overflow_q;
    assign Count    = count_q;

endmodule

// File: tb/tb_uart_tx_port.sv
// Directed bench for uart_tx_port at DIV=10, DEPTH=4; outputs are sampled 1ns after each rising edge.
module tb_uart_tx_port;

    logic        clk;
    logic        rst;
    logic [7:0]  Address;
    logic [7:0]  RegData;
    logic        EN;
    logic        TxD;
    logic        Busy;
    logic        Full;
    logic        Overflow;
    logic [4:0]  Count;

    int n_checks;
    int n_errors;
    int max_cnt;

    uart_tx_port #(
        .CLK_HZ (1000),
        .BAUD   (100),
        .DEPTH  (4),
        .ADDR   (8'hFE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .Address  (Address),
        .RegData  (RegData),
        .EN       (EN),
        .TxD      (TxD),
        .Busy     (Busy),
        .Full     (Full),
        .Overflow (Overflow),
        .Count    (Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (int'(Count) > max_cnt) max_cnt = int'(Count);
    endtask

    // One-cycle store pulse; returns 1ns after the edge that samples it.
    task automatic push(input logic [7:0] addr, input logic [7:0] data);
        Address = addr;
        RegData = data;
        EN      = 1'b1;
        step();
        EN      = 1'b0;
    endtask

    // Check a whole 8N1 frame cycle by cycle, starting at frame cycle first_i.
    // EN is raised with on_data at index en_on and dropped at index en_off.
    task automatic expect_frame(input logic [7:0] d, input int first_i,
                                input int en_on, input int en_off, input logic [7:0] on_data);
        logic [9:0] frame;
        frame = {1'b1, d, 1'b0};
        for (int i = first_i; i < 100; i++) begin
            if (i > first_i) step();
            if (i == en_on) begin
                Address = 8'hFE;
                RegData = on_data;
                EN      = 1'b1;
            end
            if (i == en_off) EN = 1'b0;
            check_eq($sformatf("txd_%02h_c%0d", d, i), {31'd0, TxD}, {31'd0, frame[i / 10]});
            check_eq($sformatf("busy_%02h_c%0d", d, i), {31'd0, Busy}, 32'd1);
        end
    endtask

    initial begin
        int bad;
        n_checks = 0;
        n_errors = 0;
        max_cnt  = 0;
        rst      = 1'b1;
        EN       = 1'b0;
        Address  = 8'h00;
        RegData  = 8'h00;

        // Reset state
        step();
        step();
        check_eq("rst_txd",  {31'd0, TxD},      32'd1);
        check_eq("rst_busy", {31'd0, Busy},     32'd0);
        check_eq("rst_full", {31'd0, Full},     32'd0);
        check_eq("rst_ovf",  {31'd0, Overflow}, 32'd0);
        check_eq("rst_cnt",  {27'd0, Count},    32'd0);
        rst = 1'b0;
        step();

        // Single byte A5
        push(8'hFE, 8'hA5);
        check_eq("a5_cnt_push", {27'd0, Count}, 32'd1);
        check_eq("a5_txd_push", {31'd0, TxD},   32'd1);
        step();
        check_eq("a5_cnt_pop", {27'd0, Count}, 32'd0);
        expect_frame(8'hA5, 0, -1, -1, 8'h00);
        step();
        check_eq("a5_idle_txd",  {31'd0, TxD},   32'd1);
        check_eq("a5_idle_busy", {31'd0, Busy},  32'd0);
        check_eq("a5_idle_cnt",  {27'd0, Count}, 32'd0);

        // EN held for 50 cycles: exactly one frame
        max_cnt = 0;
        Address = 8'hFE;
        RegData = 8'h41;
        EN      = 1'b1;
        step();
        check_eq("held_cnt_push", {27'd0, Count}, 32'd1);
        step();
        expect_frame(8'h41, 0, -1, 48, 8'h00);
        step();
        check_eq("held_idle_busy", {31'd0, Busy},  32'd0);
        check_eq("held_idle_cnt",  {27'd0, Count}, 32'd0);
        check_eq("held_max_cnt",   max_cnt,        32'd1);

        // Same held store to a different address: ignored
        max_cnt = 0;
        bad     = 0;
        Address = 8'hFD;
        EN      = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            if (TxD !== 1'b1 || Busy !== 1'b0) bad++;
        end
        EN = 1'b0;
        check_eq("fd_max_cnt", max_cnt, 32'd0);
        check_eq("fd_line",    bad,     32'd0);

        // Overflow: six pulses two cycles apart
        push(8'hFE, 8'h01);
        step();
        check_eq("ovf_start_txd", {31'd0, TxD}, 32'd0);
        for (int d = 2; d <= 5; d++) begin
            push(8'hFE, 8'(d));
            check_eq($sformatf("ovf_cnt_%0d", d), {27'd0, Count}, 32'(d - 1));
            step();
        end
        check_eq("ovf_full",     {31'd0, Full},     32'd1);
        check_eq("ovf_pre_flag", {31'd0, Overflow}, 32'd0);
        push(8'hFE, 8'h06);
        check_eq("ovf_flag",     {31'd0, Overflow}, 32'd1);
        check_eq("ovf_cnt_drop", {27'd0, Count},    32'd4);
        expect_frame(8'h01, 9, -1, -1, 8'h00);
        for (int d = 2; d <= 5; d++) begin
            step();
            check_eq($sformatf("ovf_cnt_f%0d", d), {27'd0, Count}, 32'(5 - d));
            expect_frame(8'(d), 0, -1, -1, 8'h00);
        end
        step();
        check_eq("ovf_end_busy", {31'd0, Busy},     32'd0);
        check_eq("ovf_end_cnt",  {27'd0, Count},    32'd0);
        check_eq("ovf_end_full", {31'd0, Full},     32'd0);
        check_eq("ovf_sticky",   {31'd0, Overflow}, 32'd1);

        // Reset during DATA of the first of two queued frames
        push(8'hFE, 8'hFF);
        step();
        push(8'hFE, 8'h00);
        check_eq("mid_cnt", {27'd0, Count}, 32'd1);
        for (int i = 0; i < 25; i++) step();
        check_eq("mid_busy_pre", {31'd0, Busy}, 32'd1);
        check_eq("mid_txd_pre",  {31'd0, TxD},  32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("mid_txd",  {31'd0, TxD},      32'd1);
        check_eq("mid_cnt0", {27'd0, Count},    32'd0);
        check_eq("mid_busy", {31'd0, Busy},     32'd0);
        check_eq("mid_ovf",  {31'd0, Overflow}, 32'd0);
        bad = 0;
        for (int i = 0; i < 150; i++) begin
            step();
            if (TxD !== 1'b1 || Busy !== 1'b0) bad++;
        end
        check_eq("mid_no_frame", bad, 32'd0);

        // Push 55 while the stop bit of the AA frame is on the line
        push(8'hFE, 8'hAA);
        step();
        expect_frame(8'hAA, 0, 94, 95, 8'h55);
        check_eq("stop_cnt", {27'd0, Count}, 32'd1);
        step();
        check_eq("stop_cnt_pop", {27'd0, Count}, 32'd0);
        expect_frame(8'h55, 0, -1, -1, 8'h00);
        step();
        check_eq("stop_idle_txd",  {31'd0, TxD},  32'd1);
        check_eq("stop_idle_busy", {31'd0, Busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
